relu_maxpool_stage: RTL and testbench
=====================================

# relu_maxpool_stage

Streaming post-processing stage that sits directly downstream of the convolution chain (after the last layer of the multi-layer wrapper). It consumes one signed T-bit output element per handshake. It applies ReLU and non-overlapping max pooling of width W across each L-element output vector, and emits one pooled element per window. Both sides use the same valid/ready protocol as the convolution layers.

## Interface
- L, 6: elements per input vector (≥1).
- W, 2: pooling window width (1 ≤ W ≤ L). L need not be a multiple of W.
- T, 8: data width, signed two's complement, same width in and out.
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- s_data_in, input, T: input element (signed).
- s_valid, input, 1: upstream holds valid data.
- s_ready, output, 1: stage accepts s_data_in this cycle.
- m_data_out, output, T: pooled result (signed, always ≥ 0).
- m_valid, output, 1: m_data_out holds an unconsumed result.
- m_ready, input, 1: downstream accepts m_data_out this cycle.

## Operation
- Transfer on either port = valid && ready at a rising edge.
- State:
  - wcnt: 0..W-1, position within the window.
  - vcnt: 0..L-1, position within the vector.
  - best: T-bit running maximum.
  - Output register (m_data_out, m_valid).
- r = (s_data_in < 0) ? 0 : s_data_in. Comparison is signed; -2^(T-1) maps to 0.
- close = (wcnt == W-1) || (vcnt == L-1): the current input ends a window.
  - The last window of a vector is partial when L mod W ≠ 0. It closes at vcnt == L-1 and emits max over its L mod W elements.
- On each input transfer:
  - cand = (wcnt == 0) ? r : max(best, r).
  - If close: m_data_out ← cand, m_valid ← 1, wcnt ← 0.
    - vcnt ← (vcnt == L-1) ? 0 : vcnt+1.
  - Else: best ← cand, wcnt ← wcnt+1, vcnt ← vcnt+1.
- On an output transfer without a same-cycle load: m_valid ← 0, and m_data_out holds its value.
- Load and drain in the same cycle: the new value is loaded and m_valid stays 1.
- s_ready = !reset && !(close && m_valid && !m_ready).
  - Stall only when closing an element would overwrite an unconsumed result.
  - Non-closing elements are always accepted.
  - The combinational path from m_ready to s_ready is permitted.
- Vectors are processed back to back with no gap. vcnt wrap defines vector boundaries, and no pooling window spans two vectors.
- There is no overflow: the output is the max of values in [0, 2^(T-1)-1].

## Timing
- Reset (asynchronous assert, any cycle, including mid-vector or with m_valid=1):
  - m_valid=0, m_data_out=0, wcnt=0, vcnt=0, best=0.
  - s_ready=0 while reset is high.
  - Pending results and partial windows are discarded.
  - The first transfer after deassertion is element 0 of a new vector.
- Latency: m_valid rises on the edge that accepts the closing element, so the result is visible 1 cycle after that transfer.
- Throughput: 1 input per cycle when m_ready is held 1. Output rate is 1 per W inputs.
- Handshake rules:
  - m_valid and m_data_out are stable while m_valid=1 and m_ready=0.
  - m_valid does not depend combinationally on m_ready.
  - s_ready may toggle with m_ready. The stage never requires s_valid low before s_ready rises.
  - s_valid may be gapped arbitrarily. Counters advance only on transfers.
- W == 1: every input closes, giving a pure ReLU pass-through with 1-cycle latency and one result per input.
- W == L: one result per vector (global max-ReLU).

## Test plan
- L=6, W=2, T=8, m_ready=1. Inputs -5, 3, 7, -1, -128, -2 -> outputs 3, 7, 0, each 1 cycle after the 2nd, 4th and 6th input transfers. s_ready stays 1 throughout.
- L=5, W=2. Inputs 1, 2, 3, 4, 9, then next vector 127, -1 -> outputs 2, 4, 9 (partial window), then 127. Confirms windows do not span vectors.
- Backpressure, L=6, W=2, m_ready=0 from reset. Inputs 10, 20, 30, 40 -> m_valid=1 with data 20 held stable. s_ready drops to 0 only while 40 is presented. Raise m_ready -> 20 is consumed, 40 is accepted that same cycle, and output becomes 40.
- Gapped s_valid (1 valid every 3 cycles) with random m_ready, over 50 random vectors -> output sequence matches a software max(ReLU) model, with no loss or duplication.
- Reset mid-operation: after inputs 5, 9, 100 (m_valid=1, data 9), assert reset asynchronously between edges -> m_valid=0 and m_data_out=0 immediately. After release, inputs 1, 2 -> output 2 (the stale 100 is discarded).
- W=1, L=3. Inputs -7, 0, 127 -> outputs 0, 0, 127 at one result per cycle with continuous s_ready=1.

Source files
------------

// File: rtl/relu_maxpool_stage_if.sv
// Valid/ready stream bundle for relu_maxpool_stage.
// One interface carries both sides of the stage:
//   s_data_in  / s_valid / s_ready  : input element stream (stage is the sink)
//   m_data_out / m_valid / m_ready  : pooled result stream (stage is the source)
// Modports:
//   slave  : the stage's view
//   master : the surrounding environment's view (upstream producer + downstream consumer)
interface relu_maxpool_stage_if #(
    parameter int unsigned T = 8
);
    logic [T-1:0] s_data_in;
    logic         s_valid;
    logic         s_ready;
    logic [T-1:0] m_data_out;
    logic         m_valid;
    logic         m_ready;

    modport slave (
        input  s_data_in,
        input  s_valid,
        output s_ready,
        output m_data_out,
        output m_valid,
        input  m_ready
    );

    modport master (
        output s_data_in,
        output s_valid,
        input  s_ready,
        input  m_data_out,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/relu_maxpool_stage.sv
// ReLU followed by non-overlapping max pooling of width W over each L-element vector.
// Consumes one signed T-bit element per input transfer and emits one pooled,
// non-negative element per window; the last window of a vector may be partial.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : relu_maxpool_stage_if.slave (s_* input stream, m_* result stream)
module relu_maxpool_stage #(
    parameter int unsigned L = 6,
    parameter int unsigned W = 2,
    parameter int unsigned T = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    relu_maxpool_stage_if.slave     bus
);

    localparam int unsigned WCW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned VCW = (L > 1) ? $clog2(L) : 1;

    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [VCW-1:0] vcnt_q, vcnt_d;
    logic [T-1:0]   best_q, best_d;
    logic [T-1:0]   data_q, data_d;
    logic           valid_q, valid_d;

    logic [T-1:0]   relu_c;
    logic [T-1:0]   cand_c;
    logic           close_c;
    logic           s_ready_c;
    logic           in_xfer_c;
    logic           out_xfer_c;

    // Datapath: ReLU, running max candidate and window-close detection
    always_comb begin
        relu_c  = bus.s_data_in[T-1] ? '0 : bus.s_data_in;
        // best and relu_c are both non-negative, so an unsigned compare is exact
        cand_c  = (wcnt_q == '0) ? relu_c : ((relu_c > best_q) ? relu_c : best_q);
        close_c = (wcnt_q == WCW'(W - 1)) || (vcnt_q == VCW'(L - 1));
    end

    // Only a closing element can collide with an unconsumed result
    always_comb begin
        s_ready_c  = !reset && !(close_c && valid_q && !bus.m_ready);
        in_xfer_c  = bus.s_valid && s_ready_c;
        out_xfer_c = valid_q && bus.m_ready;
    end

    // Next-state logic
    always_comb begin
        wcnt_d  = wcnt_q;
        vcnt_d  = vcnt_q;
        best_d  = best_q;
        data_d  = data_q;
        valid_d = valid_q;

        if (out_xfer_c) begin
            valid_d = 1'b0;
        end

        if (in_xfer_c) begin
            if (close_c) begin
                // Load wins over a same-cycle drain
                data_d  = cand_c;
                valid_d = 1'b1;
                wcnt_d  = '0;
                vcnt_d  = (vcnt_q == VCW'(L - 1)) ? '0 : vcnt_q + VCW'(1);
            end else begin
                best_d  = cand_c;
                wcnt_d  = wcnt_q + WCW'(1);
                vcnt_d  = vcnt_q + VCW'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q  <= '0;
            vcnt_q  <= '0;
            best_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            vcnt_q  <= vcnt_d;
            best_q  <= best_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus.s_ready    = s_ready_c;
    assign bus.m_data_out = data_q;
    assign bus.m_valid    = valid_q;

endmodule

// File: tb/tb_relu_maxpool_stage.sv
// Self-checking bench for relu_maxpool_stage.
// Three instances share clk/reset: idx 0 = L6/W2, idx 1 = L5/W2, idx 2 = L3/W1.
module tb_relu_maxpool_stage;

    typedef logic [7:0] bq_t [$];

    logic            clk;
    logic            reset;
    logic [2:0]      sv;
    logic [2:0]      mr;
    logic [2:0][7:0] din;
    wire  [2:0]      sr;
    wire  [2:0]      mv;
    wire  [2:0][7:0] dout;

    int   tests;
    int   fails;
    bq_t  obs [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LG = (g == 0) ? 6 : ((g == 1) ? 5 : 3);
        localparam int unsigned WG = (g == 2) ? 1 : 2;

        relu_maxpool_stage_if #(.T(8)) bus ();

        assign bus.s_data_in = din[g];
        assign bus.s_valid   = sv[g];
        assign bus.m_ready   = mr[g];
        assign sr[g]         = bus.s_ready;
        assign mv[g]         = bus.m_valid;
        assign dout[g]       = bus.m_data_out;

        relu_maxpool_stage #(.L(LG), .W(WG), .T(8)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );
    end

    // Record every result that is handed downstream (sampled mid-cycle)
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                if (mv[d] && mr[d]) obs[d].push_back(dout[d]);
            end
        end
    end

    function automatic int l_of(int d);
        return (d == 0) ? 6 : ((d == 1) ? 5 : 3);
    endfunction

    function automatic int w_of(int d);
        return (d == 2) ? 1 : 2;
    endfunction

    // Reference: split stream into L-vectors, each into W-wide windows, max of ReLU
    function automatic bq_t pool_model(int l, int w, bq_t xs);
        bq_t q;
        for (int v = 0; v + l <= xs.size(); v += l) begin
            for (int s = 0; s < l; s += w) begin
                int m = 0;
                for (int k = s; k < s + w && k < l; k++) begin
                    int x = $signed(xs[v + k]);
                    if (x > m) m = x;
                end
                q.push_back(8'(m));
            end
        end
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        sv    = '0;
        mr    = '0;
        din   = '0;
        tick();
        tick();
        reset = 1'b0;
        for (int d = 0; d < 3; d++) obs[d].delete();
    endtask

    task automatic test_reset();
        tick();
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (sr[d] !== 1'b0) begin fails++; $display("FAIL reset_s_ready[%0d]: got %b expected 0", d, sr[d]); end
            tests++;
            if (mv[d] !== 1'b0) begin fails++; $display("FAIL reset_m_valid[%0d]: got %b expected 0", d, mv[d]); end
            tests++;
            if (dout[d] !== 8'd0) begin fails++; $display("FAIL reset_m_data[%0d]: got %0d expected 0", d, dout[d]); end
        end
        mr    = 3'b111;
        reset = 1'b0;
        #1;
        tests++;
        if (sr !== 3'b111) begin fails++; $display("FAIL release_s_ready: got %b expected 111", sr); end
        tick();
        tests++;
        if (mv !== 3'b000) begin fails++; $display("FAIL idle_m_valid: got %b expected 000", mv); end
    endtask

    task automatic test_basic();
        logic [7:0] xs  [6] = '{8'hFB, 8'h03, 8'h07, 8'hFF, 8'h80, 8'hFE};
        logic [7:0] exp [3] = '{8'd3, 8'd7, 8'd0};
        do_reset();
        mr[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din[0] = xs[i];
            sv[0]  = 1'b1;
            @(negedge clk);
            tests++;
            if (sr[0] !== 1'b1) begin fails++; $display("FAIL basic_s_ready[%0d]: got %b expected 1", i, sr[0]); end
            tick();
            tests++;
            if (mv[0] !== 1'(i % 2)) begin fails++; $display("FAIL basic_m_valid[%0d]: got %b expected %0d", i, mv[0], i % 2); end
            if (i % 2 == 1) begin
                tests++;
                if (dout[0] !== exp[i / 2]) begin fails++; $display("FAIL basic_data[%0d]: got %0d expected %0d", i, dout[0], exp[i / 2]); end
            end
        end
        sv[0] = 1'b0;
        tick();
        tests++;
        if (mv[0] !== 1'b0) begin fails++; $display("FAIL basic_drained: got %b expected 0", mv[0]); end
    endtask

    task automatic test_partial_window();
        logic [7:0] xs  [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd127, 8'hFF};
        logic       ev  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] exp [4] = '{8'd2, 8'd4, 8'd9, 8'd127};
        int         k = 0;
        do_reset();
        mr[1] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            din[1] = xs[i];
            sv[1]  = 1'b1;
            tick();
            tests++;
            if (mv[1] !== ev[i]) begin fails++; $display("FAIL partial_m_valid[%0d]: got %b expected %b", i, mv[1], ev[i]); end
            if (ev[i]) begin
                tests++;
                if (dout[1] !== exp[k]) begin fails++; $display("FAIL partial_data[%0d]: got %0d expected %0d", i, dout[1], exp[k]); end
                k++;
            end
        end
        sv[1] = 1'b0;
        tick();
        tests++;
        if (obs[1].size() != 4) begin fails++; $display("FAIL partial_count: got %0d expected 4", obs[1].size()); end
    endtask

    task automatic test_backpressure();
        logic [7:0] xs [3] = '{8'd10, 8'd20, 8'd30};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            din[0] = xs[i];
            sv[0]  = 1'b1;
            @(negedge clk);
            tests++;
            if (sr[0] !== 1'b1) begin fails++; $display("FAIL bp_s_ready[%0d]: got %b expected 1", i, sr[0]); end
            tick();
        end
        tests++;
        if (mv[0] !== 1'b1 || dout[0] !== 8'd20) begin fails++; $display("FAIL bp_pending: got v=%b d=%0d expected v=1 d=20", mv[0], dout[0]); end
        din[0] = 8'd40;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (sr[0] !== 1'b0) begin fails++; $display("FAIL bp_stall[%0d]: got %b expected 0", c, sr[0]); end
            tests++;
            if (mv[0] !== 1'b1 || dout[0] !== 8'd20) begin fails++; $display("FAIL bp_hold[%0d]: got v=%b d=%0d expected v=1 d=20", c, mv[0], dout[0]); end
            tick();
        end
        mr[0] = 1'b1;
        #1;
        tests++;
        if (sr[0] !== 1'b1) begin fails++; $display("FAIL bp_release: got %b expected 1", sr[0]); end
        tick();
        tests++;
        if (mv[0] !== 1'b1 || dout[0] !== 8'd40) begin fails++; $display("FAIL bp_reload: got v=%b d=%0d expected v=1 d=40", mv[0], dout[0]); end
        sv[0] = 1'b0;
        tick();
        tests++;
        if (mv[0] !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b expected 0", mv[0]); end
        tests++;
        if (obs[0].size() != 2 || obs[0][0] !== 8'd20 || obs[0][1] !== 8'd40) begin
            fails++;
            $display("FAIL bp_sequence: got %0d results expected 20,40", obs[0].size());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] xs [3] = '{8'd5, 8'd9, 8'd100};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            din[0] = xs[i];
            sv[0]  = 1'b1;
            tick();
        end
        sv[0] = 1'b0;
        tests++;
        if (mv[0] !== 1'b1 || dout[0] !== 8'd9) begin fails++; $display("FAIL rmid_before: got v=%b d=%0d expected v=1 d=9", mv[0], dout[0]); end
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if (mv[0] !== 1'b0 || dout[0] !== 8'd0) begin fails++; $display("FAIL rmid_async: got v=%b d=%0d expected v=0 d=0", mv[0], dout[0]); end
        tests++;
        if (sr[0] !== 1'b0) begin fails++; $display("FAIL rmid_s_ready: got %b expected 0", sr[0]); end
        tick();
        reset = 1'b0;
        obs[0].delete();
        mr[0] = 1'b1;
        din[0] = 8'd1;
        sv[0]  = 1'b1;
        tick();
        din[0] = 8'd2;
        tick();
        sv[0] = 1'b0;
        tick();
        tick();
        tests++;
        if (obs[0].size() != 1) begin
            fails++;
            $display("FAIL rmid_count: got %0d expected 1", obs[0].size());
        end else begin
            tests++;
            if (obs[0][0] !== 8'd2) begin fails++; $display("FAIL rmid_data: got %0d expected 2", obs[0][0]); end
        end
    endtask

    task automatic test_w1_passthrough();
        logic [7:0] xs  [3] = '{8'hF9, 8'd0, 8'd127};
        logic [7:0] exp [3] = '{8'd0, 8'd0, 8'd127};
        do_reset();
        mr[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din[2] = xs[i];
            sv[2]  = 1'b1;
            @(negedge clk);
            tests++;
            if (sr[2] !== 1'b1) begin fails++; $display("FAIL w1_s_ready[%0d]: got %b expected 1", i, sr[2]); end
            tick();
            tests++;
            if (mv[2] !== 1'b1 || dout[2] !== exp[i]) begin
                fails++;
                $display("FAIL w1_out[%0d]: got v=%b d=%0d expected v=1 d=%0d", i, mv[2], dout[2], exp[i]);
            end
        end
        sv[2] = 1'b0;
    endtask

    task automatic test_random_gapped();
        for (int d = 0; d < 3; d++) begin
            bq_t        xs;
            bq_t        exp;
            int         idx  = 0;
            int         gap  = 0;
            int         cyc  = 0;
            logic       hold = 1'b0;
            logic [7:0] hv   = '0;
            do_reset();
            for (int i = 0; i < 50 * l_of(d); i++) xs.push_back(8'($urandom));
            exp = pool_model(l_of(d), w_of(d), xs);
            while ((idx < xs.size() || obs[d].size() < exp.size()) && cyc < 8000) begin
                if (hold) begin
                    tests++;
                    if (mv[d] !== 1'b1 || dout[d] !== hv) begin
                        fails++;
                        $display("FAIL rand_hold[%0d] cyc %0d: got v=%b d=%0d expected v=1 d=%0d", d, cyc, mv[d], dout[d], hv);
                    end
                end
                mr[d] = ($urandom_range(0, 3) != 0);
                if (idx < xs.size() && gap == 0) begin
                    sv[d]  = 1'b1;
                    din[d] = xs[idx];
                end else begin
                    sv[d] = 1'b0;
                end
                @(negedge clk);
                hold = mv[d] && !mr[d];
                hv   = dout[d];
                if (sv[d] && sr[d]) begin
                    idx++;
                    gap = 2;
                end else if (!sv[d] && gap > 0) begin
                    gap--;
                end
                tick();
                cyc++;
            end
            sv[d] = 1'b0;
            mr[d] = 1'b0;
            tests++;
            if (cyc >= 8000) begin fails++; $display("FAIL rand_timeout[%0d]: got %0d inputs expected %0d", d, idx, xs.size()); end
            tests++;
            if (obs[d].size() != exp.size()) begin fails++; $display("FAIL rand_count[%0d]: got %0d expected %0d", d, obs[d].size(), exp.size()); end
            for (int i = 0; i < exp.size() && i < obs[d].size(); i++) begin
                tests++;
                if (obs[d][i] !== exp[i]) begin fails++; $display("FAIL rand_data[%0d][%0d]: got %0d expected %0d", d, i, obs[d][i], exp[i]); end
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        sv    = '0;
        mr    = '0;
        din   = '0;
        test_reset();
        test_basic();
        test_partial_window();
        test_backpressure();
        test_reset_mid();
        test_w1_passthrough();
        test_random_gapped();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
